// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIT FFT address generator.
package fft_pkg;

  localparam int LOG2_N_MAX_DEFAULT = 10;
  localparam int LOG2N_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REORDER = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit reversal of the low `width` bits of an index; bits above
// `width` in the input are expected to be zero.
module fft_bitrev
  import fft_pkg::*;
#(
  parameter int IDX_W = LOG2_N_MAX_DEFAULT
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic [LOG2N_W-1:0] width,
  output logic [IDX_W-1:0]   rev
);

  logic [IDX_W-1:0] full_rev;

  generate
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_rev
      assign full_rev[gi] = idx[IDX_W-1-gi];
    end
  endgenerate

  // Reversing all IDX_W bits leaves the wanted field at the top; slide it down.
  assign rev = full_rev >> (IDX_W - int'(width));

endmodule

// File: rtl/fft_addr_gen.sv
// Stage/butterfly/twiddle address sequencer for an in-place radix-2 DIT FFT.
// Define FFT_AG_REORDER_EN to append a bit-reversal reorder pass after the last stage.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2_N_MAX = LOG2_N_MAX_DEFAULT,
  parameter int IDX_W      = LOG2_N_MAX,
  parameter int TW_W       = LOG2_N_MAX - 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic [LOG2N_W-1:0] log2n,
  input  logic               ready,
  output logic               valid,
  output logic [IDX_W-1:0]   a_idx,
  output logic [IDX_W-1:0]   b_idx,
  output logic [TW_W-1:0]    tw_idx,
  output logic [LOG2N_W-1:0] stage,
  output logic               stage_last,
  output logic               reorder,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [LOG2N_W-1:0] ONE_L   = LOG2N_W'(1);
  localparam logic [LOG2N_W-1:0] MAX_L   = LOG2N_W'(LOG2_N_MAX);
  localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);

  state_t             state_reg, state_next;
  logic [LOG2N_W-1:0] size_reg, size_next;
  logic [LOG2N_W-1:0] s_reg, s_next;
  logic [IDX_W-1:0]   k_reg, k_next;

  logic               valid_reg, busy_reg, done_reg, err_reg, last_reg;
  logic [IDX_W-1:0]   a_reg, b_reg;
  logic [TW_W-1:0]    tw_reg;
  logic [LOG2N_W-1:0] stage_reg;

  logic               size_ok, fire;
  logic               run_next, ro_next, beat_next;
  logic [IDX_W-1:0]   half_last;
  logic [IDX_W-1:0]   span, pos, grp;
  logic [IDX_W-1:0]   a_next, b_next;
  logic [TW_W-1:0]    tw_next;
  logic [LOG2N_W-1:0] stage_next;
  logic               last_next;

  // (1 << w) - 1 in index width; wraps to all-ones when w == IDX_W.
  function automatic logic [IDX_W-1:0] low_mask(input logic [LOG2N_W-1:0] w);
    return (IDX_ONE << w) - IDX_ONE;
  endfunction

  assign size_ok   = (log2n != '0) && (log2n <= MAX_L);
  assign fire      = valid_reg && ready;
  assign half_last = low_mask(size_reg - ONE_L);

  // Next-state and counter sequencing.
  always_comb begin
    state_next = state_reg;
    size_next  = size_reg;
    s_next     = s_reg;
    k_next     = k_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start && size_ok) begin
          state_next = ST_RUN;
          size_next  = log2n;
          s_next     = '0;
          k_next     = '0;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (k_reg == half_last) begin
            k_next = '0;
            if (s_reg == size_reg - ONE_L) begin
`ifdef FFT_AG_REORDER_EN
              state_next = ST_REORDER;
              s_next     = size_reg;
`else
              state_next = ST_DONE;
`endif
            end else begin
              s_next = s_reg + ONE_L;
            end
          end else begin
            k_next = k_reg + IDX_ONE;
          end
        end
      end
`ifdef FFT_AG_REORDER_EN
      ST_REORDER: begin
        if (fire) begin
          if (k_reg == low_mask(size_reg)) begin
            state_next = ST_DONE;
          end else begin
            k_next = k_reg + IDX_ONE;
          end
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign run_next = (state_next == ST_RUN);
`ifdef FFT_AG_REORDER_EN
  assign ro_next  = (state_next == ST_REORDER);
`else
  assign ro_next  = 1'b0;
`endif
  assign beat_next = run_next || ro_next;

`ifdef FFT_AG_REORDER_EN
  logic [IDX_W-1:0] rev_k;

  fft_bitrev #(
    .IDX_W (IDX_W)
  ) u_bitrev (
    .idx   (k_next),
    .width (size_next),
    .rev   (rev_k)
  );
`endif

  // Beat contents are derived from the next counters so every output is a flop.
  always_comb begin
    span       = IDX_ONE << s_next;
    pos        = k_next & (span - IDX_ONE);
    grp        = k_next >> s_next;
    a_next     = '0;
    b_next     = '0;
    tw_next    = '0;
    stage_next = '0;
    last_next  = 1'b0;
    if (run_next) begin
      a_next     = (grp << (s_next + ONE_L)) | pos;
      b_next     = a_next + span;
      tw_next    = pos[TW_W-1:0] << (size_next - ONE_L - s_next);
      stage_next = s_next;
      last_next  = (k_next == low_mask(size_next - ONE_L));
    end
`ifdef FFT_AG_REORDER_EN
    else if (ro_next) begin
      a_next     = k_next;
      b_next     = rev_k;
      stage_next = size_next;
      last_next  = (k_next == low_mask(size_next));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg <= ST_IDLE;
      size_reg  <= '0;
      s_reg     <= '0;
      k_reg     <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      tw_reg    <= '0;
      stage_reg <= '0;
    end else begin
      state_reg <= state_next;
      size_reg  <= size_next;
      s_reg     <= s_next;
      k_reg     <= k_next;
      valid_reg <= beat_next;
      busy_reg  <= beat_next;
      // DONE is entered only from RUN/REORDER, so this is a single-cycle pulse.
      done_reg  <= (state_next == ST_DONE);
      err_reg   <= (state_reg == ST_IDLE) && start && !size_ok;
      last_reg  <= last_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      tw_reg    <= tw_next;
      stage_reg <= stage_next;
    end
  end

`ifdef FFT_AG_REORDER_EN
  logic reorder_reg;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      reorder_reg <= 1'b0;
    end else begin
      reorder_reg <= ro_next;
    end
  end

  assign reorder = reorder_reg;
`else
  assign reorder = 1'b0;
`endif

  assign valid      = valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign stage_last = last_reg;
  assign a_idx      = a_reg;
  assign b_idx      = b_reg;
  assign tw_idx     = tw_reg;
  assign stage      = stage_reg;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen: directed runs plus random ready stalls,
// checked against a butterfly-list model built from group/position arithmetic.
module tb_fft_addr_gen;
  import fft_pkg::*;

  localparam int LMAX = LOG2_N_MAX_DEFAULT;
  localparam int IW   = LMAX;
  localparam int TWW  = LMAX - 1;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic            start = 1'b0;
  logic [3:0]      log2n = '0;
  logic            ready = 1'b0;
  logic            valid;
  logic [IW-1:0]   a_idx, b_idx;
  logic [TWW-1:0]  tw_idx;
  logic [3:0]      stage;
  logic            stage_last, reorder, busy, done, err;

  fft_addr_gen #(
    .LOG2_N_MAX (LMAX),
    .IDX_W      (IW),
    .TW_W       (TWW)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .start      (start),
    .log2n      (log2n),
    .ready      (ready),
    .valid      (valid),
    .a_idx      (a_idx),
    .b_idx      (b_idx),
    .tw_idx     (tw_idx),
    .stage      (stage),
    .stage_last (stage_last),
    .reorder    (reorder),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
    bit last;
    bit ro;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_beat();
    return 64'({a_idx, b_idx, tw_idx, stage, stage_last, reorder, valid});
  endfunction

  function automatic logic [63:0] exp_beat(input beat_t e);
    return 64'({IW'(e.a), IW'(e.b), TWW'(e.tw), 4'(e.st), e.last, e.ro, 1'b1});
  endfunction

  // Each stage s splits N points into blocks of 2*2^s; butterfly p of a block
  // pairs p with p+2^s and uses twiddle p * (number of blocks).
  task automatic build(input int nl);
    int n;
    n = 1 << nl;
    exp_q.delete();
    for (int s = 0; s < nl; s++) begin
      int half;
      int blocks;
      int cnt;
      half   = 1 << s;
      blocks = n / (2 * half);
      cnt    = 0;
      for (int g = 0; g < blocks; g++) begin
        for (int p = 0; p < half; p++) begin
          beat_t e;
          e.a    = g * 2 * half + p;
          e.b    = e.a + half;
          e.tw   = p * blocks;
          e.st   = s;
          e.last = (cnt == n / 2 - 1);
          e.ro   = 1'b0;
          exp_q.push_back(e);
          cnt++;
        end
      end
    end
`ifdef FFT_AG_REORDER_EN
    for (int k = 0; k < n; k++) begin
      beat_t e;
      int r;
      r = 0;
      for (int bt = 0; bt < nl; bt++)
        if (((k >> bt) & 1) == 1) r = r | (1 << (nl - 1 - bt));
      e.a    = k;
      e.b    = r;
      e.tw   = 0;
      e.st   = nl;
      e.last = (k == n - 1);
      e.ro   = 1'b1;
      exp_q.push_back(e);
    end
`endif
  endtask

  // Called at a negedge in IDLE. hold_start keeps start high with a different
  // size for the whole run to show it is ignored while busy.
  task automatic run(input int nl, input int ready_pct, input bit hold_start);
    int idx;
    int cyc;
    int budget;
    bit fin;
    build(nl);
    idx    = 0;
    cyc    = 0;
    fin    = 1'b0;
    budget = 20 * exp_q.size() + 50;
    start  = 1'b1;
    log2n  = 4'(nl);
    ready  = 1'b0;
    @(negedge clk);
    if (hold_start) log2n = (nl == 3) ? 4'd2 : 4'd3;
    else start = 1'b0;
    while (!fin && cyc < budget) begin
      if (done) begin
        start = 1'b0;
        chk("beat_count", 64'(idx), 64'(exp_q.size()));
        chk("done_idle", {valid, busy}, 64'd0);
        fin = 1'b1;
      end else begin
        chk("busy_run", busy, 64'd1);
        ready = ($urandom_range(99) < ready_pct);
        if (valid) begin
          if (idx < exp_q.size()) chk($sformatf("beat%0d", idx), obs_beat(), exp_beat(exp_q[idx]));
          else chk("extra_beat", valid, 64'd0);
          if (ready) idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("run_finished", fin, 64'd1);
    $display("run log2n=%0d beats=%0d cycles=%0d", nl, idx, cyc);
    ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", {done, busy}, 64'd0);
  endtask

  task automatic bad_start(input int nl);
    start = 1'b1;
    log2n = 4'(nl);
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", {err, busy, valid}, 64'b100);
    @(negedge clk);
    chk("err_clear", {err, busy, valid}, 64'd0);
    $display("illegal start log2n=%0d", nl);
  endtask

  initial begin
    bit found;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_beat", obs_beat(), 64'd0);
    chk("rst_flags", {busy, done, err}, 64'd0);
    rst_ = 1'b1;
    @(negedge clk);

    run(2, 100, 1'b0);
    run(3, 60, 1'b0);
    bad_start(0);
    bad_start(LMAX + 1);
    run(3, 100, 1'b1);

    // Reset in the middle of stage 1 abandons the run with no done pulse.
    start = 1'b1;
    log2n = 4'd3;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid && stage == 4'd1) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_stage1", found, 64'd1);
    rst_ = 1'b0;
    @(negedge clk);
    chk("rst_mid", {valid, busy, done}, 64'd0);
    rst_  = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", {done, busy}, 64'd0);
    end
    $display("mid-run reset checked");

    run(LMAX, 90, 1'b0);
    for (int i = 0; i < 4; i++) run($urandom_range(6, 1), 70, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
